// File: rtl/reg_file.sv
// reg_file: RV32I integer register file.
// 32 x XLEN storage, one synchronous write port (rd) and two combinational
// read ports (rs1/rs2) with write-through bypass. x0 always reads zero.
module reg_file #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data
);

  // Register array; entry 0 is cleared on reset and never written.
  logic [XLEN-1:0] r_regs [NREGS];

  // A write is only effective for a non-zero destination.
  logic w_wr_en;
  assign w_wr_en = we && (rd_addr != {ADDR_W{1'b0}});

  // Per-port bypass hits: the port is reading the register being written.
  logic w_byp1;
  logic w_byp2;
  assign w_byp1 = w_wr_en && (rs1_addr == rd_addr);
  assign w_byp2 = w_wr_en && (rs2_addr == rd_addr);

  // Array update: async clear has priority over the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[rd_addr] <= rd_data;
    end else begin
      r_regs[rd_addr] <= r_regs[rd_addr];
    end
  end

  // Read port 1: zero in reset or for x0, bypass on a same-cycle write hit.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    if (rst || (rs1_addr == {ADDR_W{1'b0}})) begin
      rs1_data = {XLEN{1'b0}};
    end else if (w_byp1) begin
      rs1_data = rd_data;
    end else begin
      rs1_data = r_regs[rs1_addr];
    end
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    rs2_data = {XLEN{1'b0}};
    if (rst || (rs2_addr == {ADDR_W{1'b0}})) begin
      rs2_data = {XLEN{1'b0}};
    end else if (w_byp2) begin
      rs2_data = rd_data;
    end else begin
      rs2_data = r_regs[rs2_addr];
    end
  end

endmodule

// File: doc/reg_file.md
# reg_file

RV32I integer register file: 32 general-purpose registers of XLEN bits, one synchronous write port and two combinational read ports with write-through bypass. It is the storage element read by decode (rs1/rs2) and written by writeback (rd), built from the same edge-triggered storage primitive as the standalone D flip-flop. Register x0 is hardwired to zero.

## Interface
- XLEN, 32, data width of each register and of all data ports
- NREGS, 32, number of architectural registers; must be a power of two
- ADDR_W, 5, register index width; must equal log2(NREGS)

- clk  input  1  rising-edge clock for all state
- rst  input  1  asynchronous, active-high reset; clears every register
- we  input  1  write enable for the rd port, sampled on the rising edge of clk
- rd_addr  input  ADDR_W  destination register index
- rd_data  input  XLEN  write data
- rs1_addr  input  ADDR_W  read port 1 index
- rs2_addr  input  ADDR_W  read port 2 index
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs2_data  output  XLEN  read port 2 data (combinational)

## Operation
- Storage: NREGS x XLEN flip-flop array, indices 0..NREGS-1.
- Write: on a rising edge of clk with rst low, if we=1 and rd_addr!=0, regs[rd_addr] <= rd_data. Otherwise, no state changes.
- Write to x0 (rd_addr=0, we=1) is discarded; regs[0] stays 0 permanently.
- Read: rsN_data = 0 when rsN_addr=0; otherwise regs[rsN_addr].
- Bypass: if we=1, rd_addr!=0 and rsN_addr==rd_addr in the same cycle, rsN_data = rd_data (the value being written), not the stale array content. Both ports bypass independently; both may bypass at once.
- Both read ports may address the same register; they return identical data.
- No state machine; the only state is the register array.

## Timing
- Reset: while rst=1, all registers read 0 and rs1_data/rs2_data = 0 for every address. Assertion takes effect immediately and does not wait for a clock edge.
- Reset has priority over write: a clock edge with rst=1 and we=1 writes nothing.
- Reset release mid-operation: the first edge with rst=0 performs a normal write. Bypass is suppressed while rst=1 (outputs stay 0).
- Write latency: data presented with we=1 is stored at the next rising edge. The same value is visible on the read ports in the same cycle through the bypass, and from the array thereafter.
- Read latency: 0 cycles. Outputs settle combinationally from the addresses, we, rd_addr and rd_data.
- Width: no truncation or extension. rd_data is stored as exactly XLEN bits.
- Out-of-range addresses cannot occur, because NREGS = 2^ADDR_W.

## Test plan
- Reset: assert rst for 2 cycles after random writes -> every address 0..31 on both ports reads 0x00000000. Deassert -> values still 0 until written.
- Write/read: write 0xDEADBEEF to x5, then 0x12345678 to x31 -> next cycle rs1_addr=5 gives 0xDEADBEEF and rs2_addr=31 gives 0x12345678. All other registers read 0.
- x0 immutability: we=1, rd_addr=0, rd_data=0xFFFFFFFF -> rs1_addr=0 reads 0 both in the same cycle (no bypass) and the cycle after.
- Bypass: x7 holds 0x00000001; same cycle we=1, rd_addr=7, rd_data=0x000000AA, rs1_addr=rs2_addr=7 -> both ports read 0x000000AA before the edge. After the edge the array holds 0x000000AA.
- we=0 with rd_addr=7 and rd_data=0x55 -> x7 is unchanged, and no bypass occurs.
- Async reset mid-cycle: x3=0x0000000F, assert rst between clock edges -> rs1_data (addr 3) drops to 0 before the next edge. A write presented during reset is not stored.
